// File: rtl/rv_pkg.sv
// rv_pkg: shared limits and pair-slot packing for the root-voter cell.
package rv_pkg;
    localparam int MAX_SETS_LIMIT = 16;
    localparam int PAIR_BITS = 120;
    localparam int CNT_W = 4;

    // Slot of pair (i,j), i<j, in row-major upper-triangle order for n datasets
    function automatic logic [6:0] pair_idx(input int i, input int j, input int n);
        return 7'((i * (2 * n - i - 1)) / 2 + (j - i - 1));
    endfunction
endpackage

// File: rtl/compare_unit_if.sv
// compare_unit_if: dataset inputs and comparison results of the voter compare unit.
interface compare_unit_if import rv_pkg::*; #(
    parameter int REG_DATA_WIDTH = 64,
    parameter int MAX_DATASETS = 9
);
    logic en;
    logic [REG_DATA_WIDTH-1:0] sets [MAX_DATASETS];
    logic [3:0] used_datasets;
    logic [CNT_W-1:0] match_cnt [MAX_DATASETS];
    logic [PAIR_BITS-1:0] match_vector;
    logic done;
    modport master(output en, sets, used_datasets, input match_cnt, match_vector, done);
    modport slave(input en, sets, used_datasets, output match_cnt, match_vector, done);
endinterface

// File: rtl/counter.sv
// counter: loadable down-counter timeout timer that saturates at zero.
module counter #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DWIDTH-1:0] d,
    input  logic              en,
    output logic              expired
);
    logic [DWIDTH-1:0] count;
    always_ff @(posedge clk) begin
        if (reset) count <= '0;
        else if (load) count <= d;
        else if (en && count != '0) count <= count - DWIDTH'(1);
    end
    assign expired = (count == '0);
endmodule

// File: rtl/compare_unit.sv
// compare_unit: sequential N-modular comparator, one dataset row per enabled cycle.
module compare_unit import rv_pkg::*; #(
    parameter int REG_DATA_WIDTH = 64,
    parameter int MAX_DATASETS = 9,
    parameter int COUNT_MATCHES = 1,
    parameter int LIST_MATCHES = 0
) (
    input logic clk,
    input logic reset,
    compare_unit_if.slave bus
);
    localparam int N = MAX_DATASETS;
    logic [REG_DATA_WIDTH-1:0] s [N];
    logic [N-1:0] eq [N];
    logic [4:0] idx, u;
    logic done;
    logic [CNT_W-1:0] cnt [N];
    logic [CNT_W-1:0] row_cnt;
    logic [PAIR_BITS-1:0] mv, row_mv;

    assign s = bus.sets;
    assign u = ({1'b0, bus.used_datasets} > 5'(N)) ? 5'(N) : {1'b0, bus.used_datasets};

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            assign eq[i][j] = (i != j) && (s[i] == s[j]);
        end
    end

    // Only the current row contributes; partners beyond U are inactive
    always_comb begin
        row_cnt = '0;
        row_mv = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (5'(i) == idx && 5'(j) < u && eq[i][j]) begin
                    row_cnt = row_cnt + CNT_W'(1);
                    if (j > i) row_mv[pair_idx(i, j, N)] = 1'b1;
                end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx <= '0;
            done <= 1'b0;
            mv <= '0;
            for (int i = 0; i < N; i++) cnt[i] <= '0;
        end else if (bus.en && !done) begin
            if (idx >= u) done <= 1'b1;
            else begin
                idx <= idx + 5'd1;
                if (idx + 5'd1 == u) done <= 1'b1;
                if (COUNT_MATCHES != 0)
                    for (int i = 0; i < N; i++) if (5'(i) == idx) cnt[i] <= row_cnt;
                if (LIST_MATCHES != 0) mv <= mv | row_mv;
            end
        end
    end

    assign bus.match_cnt = cnt;
    assign bus.match_vector = mv;
    assign bus.done = done;
endmodule

// File: tb/tb_compare_unit.sv
// tb_compare_unit: vector table, hand sequences and random runs against a pairwise model.
module tb_compare_unit;
    localparam logic [63:0] A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] B = 64'hFEDC_BA98_7654_3210;

    typedef struct {
        int used;
        logic [63:0] v [9];
        int cnt [9];
    } vec_t;

    logic clk = 0, reset = 0;
    logic ld = 0, cen = 0, expd;
    logic [31:0] dd = 0;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    compare_unit_if #(.REG_DATA_WIDTH(64), .MAX_DATASETS(9)) bus();
    compare_unit #(.REG_DATA_WIDTH(64), .MAX_DATASETS(9), .COUNT_MATCHES(1), .LIST_MATCHES(1))
        dut (.clk(clk), .reset(reset), .bus(bus));
    counter #(.DWIDTH(32)) ctr (.clk(clk), .reset(reset), .load(ld), .d(dd), .en(cen), .expired(expd));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1;
        bus.en = 0;
        tick();
        reset = 0;
    endtask

    // Count equal partners directly and walk pair slots in enumeration order
    task automatic model(input int used, input logic [63:0] v [9], output int ec [9], output logic [119:0] emv);
        int uu, k;
        uu = used > 9 ? 9 : used;
        k = 0;
        emv = '0;
        for (int i = 0; i < 9; i++) begin
            ec[i] = 0;
            if (i < uu)
                for (int j = 0; j < uu; j++) if (j != i && v[j] == v[i]) ec[i]++;
        end
        for (int i = 0; i < 9; i++)
            for (int j = i + 1; j < 9; j++) begin
                if (i < uu && j < uu && v[i] == v[j]) emv[k] = 1'b1;
                k++;
            end
    endtask

    task automatic run(input string nm, input int used, input logic [63:0] v [9], input int pa, input int pl);
        int ne, tot, pc, lat;
        int ec [9];
        logic [119:0] emv;
        ne = 0; tot = 0; pc = 0;
        lat = used == 0 ? 1 : (used > 9 ? 9 : used);
        bus.used_datasets = 4'(used);
        bus.sets = v;
        do_reset();
        while (bus.done !== 1'b1 && tot < 200) begin
            bus.en = !(ne == pa && pc < pl);
            if (!bus.en) pc++;
            tick();
            tot++;
            if (bus.en) ne++;
        end
        bus.en = 0;
        model(used, v, ec, emv);
        chk({nm, " done"}, 128'(bus.done), 1);
        chk({nm, " en_cycles"}, 128'(ne), 128'(lat));
        chk({nm, " total_cycles"}, 128'(tot), 128'(lat + pl));
        for (int i = 0; i < 9; i++) chk($sformatf("%s cnt[%0d]", nm, i), 128'(bus.match_cnt[i]), 128'(ec[i]));
        chk({nm, " vector"}, 128'(bus.match_vector), 128'(emv));
    endtask

    initial begin
        vec_t tbl [7];
        logic [63:0] v [9];
        logic [63:0] pool [3];
        int ec [9];
        logic [119:0] emv;
        tbl[0].used = 3; tbl[0].v = '{A, A, A, A, A, A, A, A, A}; tbl[0].cnt = '{2, 2, 2, 0, 0, 0, 0, 0, 0};
        tbl[1].used = 3; tbl[1].v = '{A, B, A, A, A, A, A, A, A}; tbl[1].cnt = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
        tbl[2].used = 9; tbl[2].v = '{1, 2, 3, 4, 5, 6, 7, 8, 9}; tbl[2].cnt = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].used = 0; tbl[3].v = '{A, A, A, A, A, A, A, A, A}; tbl[3].cnt = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].used = 15; tbl[4].v = '{B, B, B, B, B, B, B, B, B}; tbl[4].cnt = '{8, 8, 8, 8, 8, 8, 8, 8, 8};
        tbl[5].used = 4; tbl[5].v = '{A, B, A, B, 0, 0, 0, 0, 0}; tbl[5].cnt = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
        tbl[6].used = 2; tbl[6].v = '{A, A ^ 64'h8000_0000_0000_0000, A, A, A, A, A, A, A};
        tbl[6].cnt = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        bus.en = 0;
        bus.used_datasets = 0;
        bus.sets = tbl[2].v;

        do_reset();
        tick();
        tick();
        chk("reset done", 128'(bus.done), 0);
        for (int i = 0; i < 9; i++) chk($sformatf("reset cnt[%0d]", i), 128'(bus.match_cnt[i]), 0);
        chk("reset vector", 128'(bus.match_vector), 0);
        chk("ctr reset expired", 128'(expd), 1);

        for (int k = 0; k < 7; k++) begin
            run($sformatf("tbl%0d", k), tbl[k].used, tbl[k].v, 99, 0);
            for (int i = 0; i < 9; i++)
                chk($sformatf("tbl%0d exp cnt[%0d]", k, i), 128'(bus.match_cnt[i]), 128'(tbl[k].cnt[i]));
            if (k == 1) chk("tbl1 vector bit1 only", 128'(bus.match_vector), 128'h2);
        end

        run("pause", 9, tbl[2].v, 4, 2);

        // Reset in the middle of a run, then a fresh unreset run
        v = '{A, A, A, A, A, B, B, B, B};
        bus.used_datasets = 5;
        bus.sets = v;
        do_reset();
        bus.en = 1;
        tick();
        tick();
        chk("mid cnt0 before reset", 128'(bus.match_cnt[0]), 4);
        reset = 1;
        tick();
        reset = 0;
        chk("mid reset done", 128'(bus.done), 0);
        chk("mid reset cnt0", 128'(bus.match_cnt[0]), 0);
        chk("mid reset cnt1", 128'(bus.match_cnt[1]), 0);
        chk("mid reset vector", 128'(bus.match_vector), 0);
        for (int c = 0; c < 4; c++) tick();
        chk("restart done at 4", 128'(bus.done), 0);
        tick();
        chk("restart done at 5", 128'(bus.done), 1);
        model(5, v, ec, emv);
        for (int i = 0; i < 9; i++) chk($sformatf("restart cnt[%0d]", i), 128'(bus.match_cnt[i]), 128'(ec[i]));

        // Outputs freeze once done, whatever the inputs do
        bus.sets = tbl[2].v;
        bus.used_datasets = 9;
        for (int c = 0; c < 3; c++) tick();
        bus.en = 0;
        chk("hold done", 128'(bus.done), 1);
        for (int i = 0; i < 9; i++) chk($sformatf("hold cnt[%0d]", i), 128'(bus.match_cnt[i]), 128'(ec[i]));
        chk("hold vector", 128'(bus.match_vector), 128'(emv));

        pool = '{A, B, A ^ 64'h1};
        for (int r = 0; r < 25; r++) begin
            int uu, lat;
            uu = $urandom_range(0, 15);
            lat = uu == 0 ? 1 : (uu > 9 ? 9 : uu);
            for (int i = 0; i < 9; i++) v[i] = pool[$urandom_range(0, 2)];
            run($sformatf("rnd%0d", r), uu, v, $urandom_range(0, lat - 1), $urandom_range(0, 3));
        end

        ld = 1; dd = 5; tick(); ld = 0;
        chk("ctr loaded", 128'(expd), 0);
        cen = 1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk($sformatf("ctr step%0d", c), 128'(expd), 0);
        end
        tick();
        chk("ctr expire", 128'(expd), 1);
        tick();
        tick();
        chk("ctr hold zero", 128'(expd), 1);
        ld = 1; dd = 3; tick(); ld = 0;
        tick();
        tick();
        chk("ctr load+en not yet", 128'(expd), 0);
        tick();
        chk("ctr load+en expire", 128'(expd), 1);
        cen = 0;
        ld = 1; dd = 0; tick(); ld = 0;
        chk("ctr load zero", 128'(expd), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
